// File: rtl/neuron_step_scheduler.sv
// neuron_step_scheduler: sequences one simulation time step across NUM_NEURONS
// neuron cores. It issues an update pulse to the enabled cores and waits for them
// to go idle. It then latches the spike vector, pulses reset to the cores that
// spiked, and reports step_done. It also owns the timestep counter.
// Ports:
//   clk, rst        clock (rising edge) and async active-high reset
//   step_start      request one step (sampled in IDLE only)
//   enable_mask     cores to update this step (latched with step_start)
//   core_busy/spike per-core busy and spike_detected inputs
//   core_update     per-core start_update pulse
//   core_reset      per-core start_reset pulse
//   ready           high in IDLE only
//   step_done       one-cycle pulse; spike_vec/timestep valid from this cycle
//   spike_vec       spikes of the last completed step
//   timestep        completed-step count
//   timeout_err     sticky watchdog abort flag
//   overrun_err     sticky step_start-while-busy flag
module neuron_step_scheduler #(
   parameter int unsigned NUM_NEURONS = 8,
   parameter int unsigned TIMEOUT     = 64,
   parameter int unsigned TS_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   step_start,
   input  logic [NUM_NEURONS-1:0] enable_mask,
   input  logic [NUM_NEURONS-1:0] core_busy,
   input  logic [NUM_NEURONS-1:0] core_spike,
   output logic [NUM_NEURONS-1:0] core_update,
   output logic [NUM_NEURONS-1:0] core_reset,
   output logic                   ready,
   output logic                   step_done,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic [TS_WIDTH-1:0]    timestep,
   output logic                   timeout_err,
   output logic                   overrun_err
);

   localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UPD_ISSUE,
      S_UPD_SETTLE,
      S_UPD_WAIT,
      S_RST_ISSUE,
      S_RST_SETTLE,
      S_RST_WAIT,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_NEURONS-1:0] mask_q, mask_d;
   logic [NUM_NEURONS-1:0] spk_q, spk_d;
   logic [WD_W-1:0]        wd_q, wd_d;
   logic [NUM_NEURONS-1:0] update_q, update_d;
   logic [NUM_NEURONS-1:0] reset_q, reset_d;
   logic                   ready_q, ready_d;
   logic                   done_q, done_d;
   logic [NUM_NEURONS-1:0] spike_vec_q, spike_vec_d;
   logic [TS_WIDTH-1:0]    timestep_q, timestep_d;
   logic                   timeout_q, timeout_d;
   logic                   overrun_q, overrun_d;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mask_q      <= '0;
         spk_q       <= '0;
         wd_q        <= '0;
         update_q    <= '0;
         reset_q     <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         spike_vec_q <= '0;
         timestep_q  <= '0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         spk_q       <= spk_d;
         wd_q        <= wd_d;
         update_q    <= update_d;
         reset_q     <= reset_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         spike_vec_q <= spike_vec_d;
         timestep_q  <= timestep_d;
         timeout_q   <= timeout_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next state; outputs are decoded from the next state so they align with it
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      spk_d       = spk_q;
      wd_d        = wd_q;
      timeout_d   = timeout_q;
      overrun_d   = overrun_q;
      spike_vec_d = spike_vec_q;
      timestep_d  = timestep_q;

      unique case (state_q)
         S_IDLE: begin
            if (step_start) begin
               mask_d  = enable_mask;
               spk_d   = '0;
               state_d = (enable_mask == '0) ? S_DONE : S_UPD_ISSUE;
            end
         end
         S_UPD_ISSUE:  state_d = S_UPD_SETTLE;
         S_UPD_SETTLE: begin
            wd_d    = '0;
            state_d = S_UPD_WAIT;
         end
         S_UPD_WAIT: begin
            if (|(core_busy & mask_q)) begin
               if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  // Abort: keep spikes only from cores that did finish, skip resets
                  timeout_d = 1'b1;
                  spk_d     = core_spike & mask_q & ~core_busy;
                  state_d   = S_DONE;
               end else begin
                  wd_d = wd_q + WD_W'(1);
               end
            end else begin
               spk_d   = core_spike & mask_q;
               state_d = (|(core_spike & mask_q)) ? S_RST_ISSUE : S_DONE;
            end
         end
         S_RST_ISSUE:  state_d = S_RST_SETTLE;
         S_RST_SETTLE: begin
            wd_d    = '0;
            state_d = S_RST_WAIT;
         end
         S_RST_WAIT: begin
            if (|(core_busy & spk_q)) begin
               if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  wd_d = wd_q + WD_W'(1);
               end
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      if (step_start && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end

      update_d = (state_d == S_UPD_ISSUE) ? mask_d : '0;
      reset_d  = (state_d == S_RST_ISSUE) ? spk_d : '0;
      ready_d  = (state_d == S_IDLE);
      done_d   = (state_d == S_DONE);
      if (state_d == S_DONE) begin
         spike_vec_d = spk_d;
         timestep_d  = timestep_q + TS_WIDTH'(1);
      end
   end

   assign core_update = update_q;
   assign core_reset  = reset_q;
   assign ready       = ready_q;
   assign step_done   = done_q;
   assign spike_vec   = spike_vec_q;
   assign timestep    = timestep_q;
   assign timeout_err = timeout_q;
   assign overrun_err = overrun_q;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// tb_neuron_step_scheduler: drives time steps into neuron_step_scheduler with
// behavioural neuron-core models and checks each step_done against a scoreboard.
module tb_neuron_step_scheduler;

   localparam int unsigned NN  = 4;
   localparam int unsigned TO  = 64;
   localparam int unsigned TSW = 4;

   typedef struct packed {
      logic [NN-1:0]  upd;
      logic [NN-1:0]  rst;
      logic [NN-1:0]  spk;
      logic [TSW-1:0] ts;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           step_start = 1'b0;
   logic [NN-1:0]  enable_mask = '0;
   logic [NN-1:0]  core_busy;
   logic [NN-1:0]  core_spike;
   logic [NN-1:0]  core_update;
   logic [NN-1:0]  core_reset;
   logic           ready;
   logic           step_done;
   logic [NN-1:0]  spike_vec;
   logic [TSW-1:0] timestep;
   logic           timeout_err;
   logic           overrun_err;

   logic [NN-1:0]  spike_cfg = '0;
   logic [NN-1:0]  stuck = '0;
   logic [TSW-1:0] ts_m = '0;
   int             cnt [NN];
   exp_t           sb [$];
   int             n_tests = 0;
   int             n_fail  = 0;
   int             done_cnt = 0;
   logic [NN-1:0]  upd_or, rst_or;
   int             upd_cycles, rst_cycles, overlap;

   neuron_step_scheduler #(.NUM_NEURONS(NN), .TIMEOUT(TO), .TS_WIDTH(TSW)) dut (
      .clk         (clk),
      .rst         (rst),
      .step_start  (step_start),
      .enable_mask (enable_mask),
      .core_busy   (core_busy),
      .core_spike  (core_spike),
      .core_update (core_update),
      .core_reset  (core_reset),
      .ready       (ready),
      .step_done   (step_done),
      .spike_vec   (spike_vec),
      .timestep    (timestep),
      .timeout_err (timeout_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Core models: busy rises the cycle after a pulse and lasts 3+i cycles (2 after reset)
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < NN; i++) begin
         if (rst)                 cnt[i] <= 0;
         else if (core_update[i]) cnt[i] <= 3 + i;
         else if (core_reset[i])  cnt[i] <= 2;
         else if (cnt[i] != 0)    cnt[i] <= cnt[i] - 1;
      end
   end

   always_comb begin
      core_busy = '0;
      for (int i = 0; i < NN; i++) core_busy[i] = (cnt[i] != 0) | stuck[i];
      core_spike = spike_cfg;
   end

   // Monitor: accumulate pulses per step and score each step_done
   always @(negedge clk) begin
      if (rst) begin
         upd_or = '0; rst_or = '0; upd_cycles = 0; rst_cycles = 0; overlap = 0;
      end else begin
         if (core_update != '0) begin upd_or |= core_update; upd_cycles++; end
         if (core_reset != '0)  begin rst_or |= core_reset;  rst_cycles++; end
         if (core_update != '0 && core_reset != '0) overlap++;
         if (step_done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(1), 32'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("spike_vec", 32'(spike_vec), 32'(e.spk));
               check("timestep", 32'(timestep), 32'(e.ts));
               check("update_bits", 32'(upd_or), 32'(e.upd));
               check("update_cycles", 32'(upd_cycles), (e.upd != '0) ? 32'(1) : 32'(0));
               check("reset_bits", 32'(rst_or), 32'(e.rst));
               check("reset_cycles", 32'(rst_cycles), (e.rst != '0) ? 32'(1) : 32'(0));
               check("pulse_overlap", 32'(overlap), 32'(0));
               check("ready_in_done", 32'(ready), 32'(0));
            end
            upd_or = '0; rst_or = '0; upd_cycles = 0; rst_cycles = 0; overlap = 0;
            done_cnt++;
         end
      end
   end

   task automatic wait_ready();
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (ready) got = 1;
         else begin @(posedge clk); #1; end
      end
      check("ready_before_step", 32'(ready), 32'(1));
   endtask

   // One full step; ov_at>0 pulses step_start again on that cycle of the step
   task automatic run_step(input logic [NN-1:0] mask, input int ov_at, output int iters);
      exp_t e;
      int   d0;
      bit   got;
      wait_ready();
      e.upd = mask;
      e.spk = spike_cfg & mask & ~stuck;
      e.rst = (|(stuck & mask)) ? '0 : e.spk;
      ts_m  = ts_m + TSW'(1);
      e.ts  = ts_m;
      sb.push_back(e);
      d0 = done_cnt;
      enable_mask = mask;
      step_start  = 1'b1;
      @(posedge clk); #1;
      step_start  = 1'b0;
      enable_mask = ~mask;
      iters = 0;
      got   = 0;
      for (int i = 1; i <= int'(TO) + 4 && !got; i++) begin
         step_start = (i == ov_at);
         @(posedge clk); #1;
         iters = i;
         if (done_cnt != d0) got = 1;
      end
      step_start = 1'b0;
      check("done_in_budget", 32'(got), 32'(1));
      repeat (3) @(posedge clk);
      #1;
      check("one_done", 32'(done_cnt - d0), 32'(1));
      check("ready_after", 32'(ready), 32'(1));
   endtask

   initial begin
      int it;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'(1));
      check("rst_outs", 32'({core_update, core_reset, step_done, spike_vec}), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of UPD_WAIT
      enable_mask = 4'b1111;
      step_start  = 1'b1;
      @(posedge clk); #1;
      step_start  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_busy", 32'(ready), 32'(0));
      rst = 1'b1;
      #1;
      check("midrst_ready", 32'(ready), 32'(1));
      check("midrst_pulses", 32'({core_update, core_reset}), 32'(0));
      check("midrst_ts", 32'(timestep), 32'(0));
      check("midrst_errs", 32'({timeout_err, overrun_err}), 32'(0));
      @(posedge clk); #1;
      rst  = 1'b0;
      ts_m = '0;
      @(posedge clk); #1;

      // No spikes, all cores enabled
      spike_cfg = 4'b0000;
      run_step(4'b1111, 0, it);
      run_step(4'b1111, 0, it);

      // Cores 0 and 2 spike, core 3 masked off
      spike_cfg = 4'b1101;
      run_step(4'b0111, 0, it);

      // Empty mask
      run_step(4'b0000, 0, it);
      check("mask0_latency", 32'(it <= 2), 32'(1));

      // step_start during UPD_WAIT
      check("overrun_clear", 32'(overrun_err), 32'(0));
      spike_cfg = 4'b0000;
      run_step(4'b1111, 3, it);
      check("overrun_set", 32'(overrun_err), 32'(1));

      // Enough empty steps to wrap the timestep counter
      for (int k = 0; k < 14; k++) run_step(4'b0000, 0, it);

      // Watchdog: core 1 busy forever
      check("timeout_clear", 32'(timeout_err), 32'(0));
      spike_cfg = 4'b0111;
      stuck     = 4'b0010;
      run_step(4'b0111, 0, it);
      check("timeout_set", 32'(timeout_err), 32'(1));
      check("timeout_latency", 32'(it <= int'(TO) + 4), 32'(1));
      stuck = '0;
      repeat (4) @(posedge clk);
      #1;
      check("spike_vec_held", 32'(spike_vec), 32'(4'b0101));
      check("sb_empty", 32'(sb.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
